// File: rtl/pic_host_controller.sv
// Bus initiator for an 8259-style PIC: programs ICW1..ICW4, runs the two-pulse
// INTA acknowledge to fetch the interrupt vector, and issues OCW2 (EOI) writes.
module pic_host_controller #(
    parameter logic [7:0] ICW1         = 8'h11,
    parameter logic [7:0] ICW2         = 8'h08,
    parameter logic [7:0] ICW3         = 8'h04,
    parameter logic [7:0] ICW4         = 8'h01,
    parameter int         PULSE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       eoi_req,
    input  logic [7:0] eoi_cmd,
    input  logic       INT,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       chip_select,
    output logic       write_Enable,
    output logic       read_Enable,
    output logic       A0,
    output logic       INTA,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] vector,
    output logic       vector_valid
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] W_SETUP  = 4'd1;
    localparam logic [3:0] W_STROBE = 4'd2;
    localparam logic [3:0] W_HOLD   = 4'd3;
    localparam logic [3:0] W_RECOV  = 4'd4;
    localparam logic [3:0] READY    = 4'd5;
    localparam logic [3:0] ACK1     = 4'd6;
    localparam logic [3:0] ACK_GAP  = 4'd7;
    localparam logic [3:0] ACK2     = 4'd8;
    localparam logic [3:0] ACK_END  = 4'd9;

    localparam int               CNT_W      = $clog2(PULSE_CYCLES + 2);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(1);

    // ICW3 only exists in cascade mode (SNGL=0); ICW4 only when IC4=1.
    localparam logic [31:0] ICW_PACK = {ICW4, ICW3, ICW2, ICW1};
    localparam logic [3:0]  ICW_EN   = {ICW1[0], ~ICW1[1], 2'b11};

    logic [7:0] icw_word [4];
    logic [3:0] icw_en;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_icw
            assign icw_word[gi] = ICW_PACK[gi*8 +: 8];
            assign icw_en[gi]   = ICW_EN[gi];
        end
    endgenerate

    logic [3:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       word_reg, word_next;
    logic             eoi_wr_reg, eoi_wr_next;
    logic             eoi_pend_reg, eoi_pend_next;
    logic [7:0]       eoi_cmd_reg, eoi_cmd_next;
    logic             int_meta_reg, int_sync_reg;
    logic             a0_reg, a0_next;
    logic [7:0]       data_out_reg, data_out_next;
    logic             init_done_reg, init_done_next;
    logic [7:0]       vector_reg, vector_next;
    logic             vector_valid_reg, vector_valid_next;
    logic             data_oe_reg, cs_reg, we_reg, inta_reg, busy_reg;
    logic [1:0]       next_word;
    logic             has_next;

    // Lowest enabled word index above the one just written.
    always_comb begin
        next_word = word_reg;
        has_next  = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (icw_en[i] && (i > int'(word_reg))) begin
                next_word = 2'(i);
                has_next  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        word_next         = word_reg;
        eoi_wr_next       = eoi_wr_reg;
        eoi_pend_next     = eoi_pend_reg;
        eoi_cmd_next      = eoi_cmd_reg;
        a0_next           = a0_reg;
        data_out_next     = data_out_reg;
        init_done_next    = init_done_reg;
        vector_next       = vector_reg;
        vector_valid_next = 1'b0;

        if (eoi_req && (state_reg != IDLE)) begin
            eoi_pend_next = 1'b1;
            eoi_cmd_next  = eoi_cmd;
        end

        case (state_reg)
            IDLE, READY: begin
                if (start) begin
                    state_next     = W_SETUP;
                    word_next      = 2'd0;
                    eoi_wr_next    = 1'b0;
                    eoi_pend_next  = 1'b0;
                    init_done_next = 1'b0;
                    a0_next        = 1'b0;
                    data_out_next  = icw_word[0];
                end else if (state_reg == READY) begin
                    if (eoi_pend_reg) begin
                        state_next    = W_SETUP;
                        eoi_wr_next   = 1'b1;
                        eoi_pend_next = eoi_req;
                        a0_next       = 1'b0;
                        data_out_next = eoi_cmd_reg;
                    end else if (int_sync_reg) begin
                        state_next = ACK1;
                        cnt_next   = '0;
                    end
                end
            end
            W_SETUP: begin
                state_next = W_STROBE;
                cnt_next   = '0;
            end
            W_STROBE: begin
                if (cnt_reg == PULSE_LAST) state_next = W_HOLD;
                else                       cnt_next   = cnt_reg + 1'b1;
            end
            W_HOLD: state_next = W_RECOV;
            W_RECOV: begin
                if (eoi_wr_reg) begin
                    state_next = READY;
                end else if (has_next) begin
                    state_next    = W_SETUP;
                    word_next     = next_word;
                    a0_next       = 1'b1;
                    data_out_next = icw_word[next_word];
                end else begin
                    state_next     = READY;
                    init_done_next = 1'b1;
                end
            end
            ACK1: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = ACK_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ACK_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    state_next = ACK2;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ACK2: begin
                // The PIC drives the vector during the second pulse; grab it on the last edge.
                if (cnt_reg == PULSE_LAST) begin
                    state_next        = ACK_END;
                    vector_next       = data_in;
                    vector_valid_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ACK_END: state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            word_reg         <= '0;
            eoi_wr_reg       <= 1'b0;
            eoi_pend_reg     <= 1'b0;
            eoi_cmd_reg      <= '0;
            int_meta_reg     <= 1'b0;
            int_sync_reg     <= 1'b0;
            a0_reg           <= 1'b0;
            data_out_reg     <= '0;
            init_done_reg    <= 1'b0;
            vector_reg       <= '0;
            vector_valid_reg <= 1'b0;
            data_oe_reg      <= 1'b0;
            cs_reg           <= 1'b1;
            we_reg           <= 1'b1;
            inta_reg         <= 1'b1;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            word_reg         <= word_next;
            eoi_wr_reg       <= eoi_wr_next;
            eoi_pend_reg     <= eoi_pend_next;
            eoi_cmd_reg      <= eoi_cmd_next;
            int_meta_reg     <= INT;
            int_sync_reg     <= int_meta_reg;
            a0_reg           <= a0_next;
            data_out_reg     <= data_out_next;
            init_done_reg    <= init_done_next;
            vector_reg       <= vector_next;
            vector_valid_reg <= vector_valid_next;
            data_oe_reg      <= state_next inside {W_SETUP, W_STROBE, W_HOLD};
            cs_reg           <= !(state_next inside {W_SETUP, W_STROBE, W_HOLD});
            we_reg           <= (state_next != W_STROBE);
            inta_reg         <= !(state_next inside {ACK1, ACK2});
            busy_reg         <= !(state_next inside {IDLE, READY});
        end
    end

    assign data_out     = data_out_reg;
    assign data_oe      = data_oe_reg;
    assign chip_select  = cs_reg;
    assign write_Enable = we_reg;
    assign read_Enable  = 1'b1;
    assign A0           = a0_reg;
    assign INTA         = inta_reg;
    assign busy         = busy_reg;
    assign init_done    = init_done_reg;
    assign vector       = vector_reg;
    assign vector_valid = vector_valid_reg;

endmodule

// File: tb/tb_pic_host_controller.sv
// Directed bench for pic_host_controller: init sequences, INTA acknowledge,
// EOI writes, reset abort and ignored requests, checked against fixed cycle numbers.
module tb_pic_host_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start_a = 1'b0, eoi_req_a = 1'b0, int_a = 1'b0;
    logic [7:0] eoi_cmd_a = 8'h00, data_in_a = 8'h00;
    logic       start_b = 1'b0, eoi_req_b = 1'b0, int_b = 1'b0;
    logic [7:0] eoi_cmd_b = 8'h00, data_in_b = 8'h00;

    logic [7:0] dout_a, vec_a, dout_b, vec_b;
    logic       oe_a, cs_a, we_a, re_a, a0_a, inta_a, busy_a, idn_a, vv_a;
    logic       oe_b, cs_b, we_b, re_b, a0_b, inta_b, busy_b, idn_b, vv_b;

    pic_host_controller dut_a (
        .clk(clk), .reset(reset), .start(start_a), .eoi_req(eoi_req_a), .eoi_cmd(eoi_cmd_a),
        .INT(int_a), .data_in(data_in_a), .data_out(dout_a), .data_oe(oe_a),
        .chip_select(cs_a), .write_Enable(we_a), .read_Enable(re_a), .A0(a0_a),
        .INTA(inta_a), .busy(busy_a), .init_done(idn_a), .vector(vec_a), .vector_valid(vv_a)
    );

    pic_host_controller #(.ICW1(8'h13)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .eoi_req(eoi_req_b), .eoi_cmd(eoi_cmd_b),
        .INT(int_b), .data_in(data_in_b), .data_out(dout_b), .data_oe(oe_b),
        .chip_select(cs_b), .write_Enable(we_b), .read_Enable(re_b), .A0(a0_b),
        .INTA(inta_b), .busy(busy_b), .init_done(idn_b), .vector(vec_b), .vector_valid(vv_b)
    );

    typedef struct {
        logic       a0;
        logic [7:0] d;
        int         len;
        int         setup;
        int         fall;
        bit         ok;
    } wr_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         mon_sel = 0;
    wr_t        wq[$];
    wr_t        cur;
    int         hold_q[$];
    int         ia_start[$];
    int         ia_len[$];
    int         vv_cyc[$];
    logic [7:0] vv_val[$];
    logic       we_p, cs_p, inta_p, idn_p;
    int         cs_fall_c, we_rise_c, ist, ilen, init_rise, re_bad, cs_low_cnt;

    task automatic clear_mon();
        wq.delete(); hold_q.delete(); ia_start.delete(); ia_len.delete();
        vv_cyc.delete(); vv_val.delete();
        we_p = 1'b1; cs_p = 1'b1; inta_p = 1'b1;
        idn_p = (mon_sel != 0) ? idn_b : idn_a;
        cs_fall_c = 0; we_rise_c = -1; ist = 0; ilen = 0;
        init_rise = -1; re_bad = 0; cs_low_cnt = 0;
    endtask

    // Records bus transactions of the selected DUT for n cycles; pulses end after one cycle.
    task automatic collect(input int n);
        logic we, cs, inta, oe, a0, idn, vv, re;
        logic [7:0] d, vec;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            we   = (mon_sel != 0) ? we_b   : we_a;
            cs   = (mon_sel != 0) ? cs_b   : cs_a;
            inta = (mon_sel != 0) ? inta_b : inta_a;
            oe   = (mon_sel != 0) ? oe_b   : oe_a;
            a0   = (mon_sel != 0) ? a0_b   : a0_a;
            idn  = (mon_sel != 0) ? idn_b  : idn_a;
            vv   = (mon_sel != 0) ? vv_b   : vv_a;
            re   = (mon_sel != 0) ? re_b   : re_a;
            d    = (mon_sel != 0) ? dout_b : dout_a;
            vec  = (mon_sel != 0) ? vec_b  : vec_a;
            if (!cs) cs_low_cnt++;
            if (!cs && cs_p) cs_fall_c = cyc;
            if (cs && !cs_p && we_rise_c >= 0) hold_q.push_back(cyc - we_rise_c);
            if (!we) begin
                if (we_p) begin
                    cur.a0 = a0; cur.d = d; cur.len = 0; cur.ok = 1'b1;
                    cur.fall = cyc; cur.setup = cyc - cs_fall_c;
                end
                cur.len++;
                if (cs || !oe) cur.ok = 1'b0;
            end else if (!we_p) begin
                we_rise_c = cyc;
                wq.push_back(cur);
                $display("[%0d] write A0=%0d data=%02h strobe=%0d", cyc, cur.a0, cur.d, cur.len);
            end
            if (!inta) begin
                if (inta_p) begin ist = cyc; ilen = 0; end
                ilen++;
            end else if (!inta_p) begin
                ia_start.push_back(ist);
                ia_len.push_back(ilen);
                $display("[%0d] inta pulse start=%0d len=%0d", cyc, ist, ilen);
            end
            if (vv) begin
                vv_cyc.push_back(cyc);
                vv_val.push_back(vec);
                $display("[%0d] vector %02h", cyc, vec);
            end
            if (!re) re_bad++;
            if (idn && !idn_p && init_rise < 0) init_rise = cyc;
            we_p = we; cs_p = cs; inta_p = inta; idn_p = idn;
            @(posedge clk);
            #1;
            start_a = 1'b0; start_b = 1'b0; eoi_req_a = 1'b0; eoi_req_b = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [24:0] obs_a, obs_b;
        logic [24:0] exp_v;
        repeat (3) @(posedge clk);
        #1;
        exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
        obs_a = {cs_a, we_a, re_a, inta_a, a0_a, oe_a, busy_a, idn_a, vv_a, dout_a, vec_a};
        obs_b = {cs_b, we_b, re_b, inta_b, a0_b, oe_b, busy_b, idn_b, vv_b, dout_b, vec_b};
        total++;
        if (obs_a !== exp_v) begin
            bad++; $display("FAIL reset_state_a got=%h exp=%h", obs_a, exp_v);
        end
        total++;
        if (obs_b !== exp_v) begin
            bad++; $display("FAIL reset_state_b got=%h exp=%h", obs_b, exp_v);
        end
        reset = 1'b0;
    endtask

    task automatic test_init_default();
        int t0;
        logic [8:0] exp_w [4];
        exp_w[0] = {1'b0, 8'h11}; exp_w[1] = {1'b1, 8'h08};
        exp_w[2] = {1'b1, 8'h04}; exp_w[3] = {1'b1, 8'h01};
        mon_sel = 0;
        clear_mon();
        start_a = 1'b1;
        t0 = cyc;
        collect(28);
        total++;
        if (wq.size() != 4) begin bad++; $display("FAIL init4_count got=%0d exp=4", wq.size()); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= wq.size() || {wq[i].a0, wq[i].d} !== exp_w[i]) begin
                bad++; $display("FAIL init4_word%0d got=%h exp=%h", i, (i < wq.size()) ? {wq[i].a0, wq[i].d} : 9'h0, exp_w[i]);
            end
            total++;
            if (i >= wq.size() || wq[i].len != 2 || wq[i].setup != 1 || !wq[i].ok) begin
                bad++; $display("FAIL init4_frame%0d len=%0d setup=%0d exp len=2 setup=1 cs/oe low", i,
                                (i < wq.size()) ? wq[i].len : -1, (i < wq.size()) ? wq[i].setup : -1);
            end
            total++;
            if (i >= hold_q.size() || hold_q[i] != 1) begin
                bad++; $display("FAIL init4_hold%0d got=%0d exp=1", i, (i < hold_q.size()) ? hold_q[i] : -1);
            end
        end
        total++;
        if (init_rise != t0 + 21) begin
            bad++; $display("FAIL init4_latency got=%0d exp=%0d", init_rise - t0, 21);
        end
        total++;
        if (busy_a !== 1'b0 || re_bad != 0) begin
            bad++; $display("FAIL init4_idle_after busy=%b re_low=%0d exp busy=0 re_low=0", busy_a, re_bad);
        end
    endtask

    task automatic test_icw3_skip();
        int t0;
        logic [8:0] exp_w [3];
        exp_w[0] = {1'b0, 8'h13}; exp_w[1] = {1'b1, 8'h08}; exp_w[2] = {1'b1, 8'h01};
        mon_sel = 1;
        clear_mon();
        start_b = 1'b1;
        t0 = cyc;
        collect(24);
        total++;
        if (wq.size() != 3) begin bad++; $display("FAIL init3_count got=%0d exp=3", wq.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= wq.size() || {wq[i].a0, wq[i].d} !== exp_w[i] || wq[i].len != 2) begin
                bad++; $display("FAIL init3_word%0d got=%h exp=%h", i, (i < wq.size()) ? {wq[i].a0, wq[i].d} : 9'h0, exp_w[i]);
            end
        end
        total++;
        if (init_rise != t0 + 16) begin
            bad++; $display("FAIL init3_latency got=%0d exp=%0d", init_rise - t0, 16);
        end
        mon_sel = 0;
    endtask

    task automatic test_ack();
        int t1;
        mon_sel = 0;
        clear_mon();
        data_in_a = 8'hFF;
        int_a = 1'b1;
        t1 = cyc;
        collect(4);
        int_a = 1'b0;
        collect(4);
        data_in_a = 8'h0C;
        collect(8);
        total++;
        if (ia_start.size() != 2) begin bad++; $display("FAIL ack_pulses got=%0d exp=2", ia_start.size()); end
        total++;
        if (ia_start.size() < 1 || ia_start[0] != t1 + 3) begin
            bad++; $display("FAIL ack_int_to_inta got=%0d exp=3", (ia_start.size() > 0) ? ia_start[0] - t1 : -1);
        end
        total++;
        if (ia_start.size() < 2 || ia_len[0] != 2 || ia_len[1] != 2 || ia_start[1] - (ia_start[0] + ia_len[0]) != 2) begin
            bad++; $display("FAIL ack_shape got pulses=%0d exp two 2-clk pulses with 2-clk gap", ia_start.size());
        end
        total++;
        if (vv_cyc.size() != 1 || vv_cyc[0] != t1 + 9 || vv_val[0] !== 8'h0C) begin
            bad++; $display("FAIL ack_vector got n=%0d at=%0d val=%h exp n=1 at=9 val=0c", vv_cyc.size(),
                            (vv_cyc.size() > 0) ? vv_cyc[0] - t1 : -1, (vv_val.size() > 0) ? vv_val[0] : 8'h00);
        end
        total++;
        if (wq.size() != 0) begin bad++; $display("FAIL ack_no_write got=%0d exp=0", wq.size()); end
        data_in_a = 8'h5A;
        collect(2);
        total++;
        if (vec_a !== 8'h0C || vv_a !== 1'b0) begin
            bad++; $display("FAIL ack_vector_hold got=%h vv=%b exp=0c vv=0", vec_a, vv_a);
        end
    endtask

    task automatic test_eoi_during_ack();
        int t1;
        mon_sel = 0;
        clear_mon();
        data_in_a = 8'h0D;
        int_a = 1'b1;
        t1 = cyc;
        collect(5);
        eoi_req_a = 1'b1;
        eoi_cmd_a = 8'h20;
        collect(1);
        eoi_cmd_a = 8'h55;
        collect(12);
        int_a = 1'b0;
        collect(20);
        total++;
        if (wq.size() != 1 || {wq[0].a0, wq[0].d} !== {1'b0, 8'h20}) begin
            bad++; $display("FAIL eoi_write got n=%0d word=%h exp n=1 word=020", wq.size(),
                            (wq.size() > 0) ? {wq[0].a0, wq[0].d} : 9'h0);
        end
        total++;
        if (wq.size() < 1 || wq[0].fall != t1 + 12 || wq[0].len != 2) begin
            bad++; $display("FAIL eoi_timing got=%0d exp=12", (wq.size() > 0) ? wq[0].fall - t1 : -1);
        end
        total++;
        if (vv_cyc.size() < 1 || vv_cyc[0] != t1 + 9) begin
            bad++; $display("FAIL eoi_first_vector got=%0d exp=9", (vv_cyc.size() > 0) ? vv_cyc[0] - t1 : -1);
        end
        total++;
        if (ia_start.size() != 4 || ia_start[2] != t1 + 17 || ia_start[3] != t1 + 21) begin
            bad++; $display("FAIL eoi_int_after_write got n=%0d third=%0d exp n=4 third=17", ia_start.size(),
                            (ia_start.size() > 2) ? ia_start[2] - t1 : -1);
        end
        total++;
        if (vv_cyc.size() != 2 || vv_cyc[1] != t1 + 23) begin
            bad++; $display("FAIL eoi_second_vector got n=%0d exp n=2 at 23", vv_cyc.size());
        end
    endtask

    task automatic test_start_ignored_in_ack();
        mon_sel = 0;
        clear_mon();
        int_a = 1'b1;
        collect(4);
        start_a = 1'b1;
        int_a = 1'b0;
        collect(20);
        total++;
        if (wq.size() != 0 || cs_low_cnt != 0) begin
            bad++; $display("FAIL start_in_ack_writes got=%0d cs_low=%0d exp=0", wq.size(), cs_low_cnt);
        end
        total++;
        if (ia_start.size() != 2 || idn_a !== 1'b1 || busy_a !== 1'b0) begin
            bad++; $display("FAIL start_in_ack_state pulses=%0d init_done=%b busy=%b exp 2/1/0", ia_start.size(), idn_a, busy_a);
        end
    endtask

    task automatic test_reset_mid_strobe();
        mon_sel = 0;
        clear_mon();
        eoi_req_a = 1'b1;
        eoi_cmd_a = 8'h20;
        collect(3);
        total++;
        if (we_a !== 1'b0 || idn_a !== 1'b1) begin
            bad++; $display("FAIL rst_precond we=%b init_done=%b exp we=0 init_done=1", we_a, idn_a);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({we_a, cs_a, inta_a, oe_a} !== 4'b1110) begin
            bad++; $display("FAIL rst_strobes got=%b exp=1110", {we_a, cs_a, inta_a, oe_a});
        end
        total++;
        if (idn_a !== 1'b0 || busy_a !== 1'b0 || vec_a !== 8'h00) begin
            bad++; $display("FAIL rst_status init_done=%b busy=%b vector=%h exp 0/0/00", idn_a, busy_a, vec_a);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_idle_eoi_and_restart();
        int t0;
        mon_sel = 0;
        clear_mon();
        eoi_req_a = 1'b1;
        eoi_cmd_a = 8'h77;
        collect(8);
        total++;
        if (wq.size() != 0 || cs_low_cnt != 0 || busy_a !== 1'b0) begin
            bad++; $display("FAIL idle_eoi got writes=%0d cs_low=%0d busy=%b exp 0/0/0", wq.size(), cs_low_cnt, busy_a);
        end
        clear_mon();
        start_a = 1'b1;
        t0 = cyc;
        collect(26);
        total++;
        if (wq.size() != 4 || {wq[0].a0, wq[0].d} !== {1'b0, 8'h11} || {wq[3].a0, wq[3].d} !== {1'b1, 8'h01}) begin
            bad++; $display("FAIL restart_words got n=%0d first=%h exp n=4 first=011", wq.size(),
                            (wq.size() > 0) ? {wq[0].a0, wq[0].d} : 9'h0);
        end
        total++;
        if (init_rise != t0 + 21) begin
            bad++; $display("FAIL restart_latency got=%0d exp=21", init_rise - t0);
        end
    endtask

    initial begin
        test_reset();
        test_init_default();
        test_icw3_skip();
        test_ack();
        test_eoi_during_ack();
        test_start_ignored_in_ack();
        test_reset_mid_strobe();
        test_idle_eoi_and_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pic_host_controller.md
# pic_host_controller

CPU-side bus initiator for the 8259 PIC core. After `start`, it writes the ICW1–ICW4 initialization sequence over the PIC's active-low chip-select/write/A0 bus. It then watches `INT`, runs the two-pulse `INTA` acknowledge cycle, and captures the interrupt vector the PIC drives on the second pulse. It also issues OCW2 (EOI) writes on request, so the PIC has a synthesizable bus master in place of a hand-written stimulus sequence.

## Interface
- `ICW1`, 8'h11, init word 1; bit1 (SNGL) = 1 skips ICW3, bit0 (IC4) = 0 skips ICW4.
- `ICW2`, 8'h08, vector base (T7–T3).
- `ICW3`, 8'h04, cascade word.
- `ICW4`, 8'h01, mode word.
- `PULSE_CYCLES`, 2, low width of each `write_Enable`/`INTA` strobe in clocks (≥1).
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  1-cycle pulse; begins (re)initialization.
- `eoi_req`  in  1  1-cycle pulse; request OCW2 write of `eoi_cmd`.
- `eoi_cmd`  in  8  OCW2 value, captured when `eoi_req` is accepted.
- `INT`  in  1  PIC interrupt output, asynchronous, active-high.
- `data_in`  in  8  PIC data bus (read side).
- `data_out`  out  8  value driven onto the data bus.
- `data_oe`  out  1  1 = drive `data_out` onto the bus.
- `chip_select`  out  1  active-low.
- `write_Enable`  out  1  active-low write strobe.
- `read_Enable`  out  1  active-low; always held at 1.
- `A0`  out  1  register select.
- `INTA`  out  1  active-low interrupt acknowledge.
- `busy`  out  1  1 while any write or ack sequence is in progress.
- `init_done`  out  1  1 after the last ICW is written; cleared by reset or `start`.
- `vector`  out  8  last captured vector; held until the next capture.
- `vector_valid`  out  1  1-cycle pulse when `vector` updates.

## Operation
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, W_RECOV, READY, ACK1, ACK_GAP, ACK2, ACK_END.
- Write word list:
  - ICW1 with A0=0.
  - ICW2 with A0=1.
  - ICW3 with A0=1, only if ICW1[1]=0.
  - ICW4 with A0=1, only if ICW1[0]=1.
- Write cycle for one word:
  - W_SETUP (1 clk): `chip_select`=0; `A0` and `data_out` valid; `data_oe`=1.
  - W_STROBE (`PULSE_CYCLES` clks): `write_Enable`=0.
  - W_HOLD (1 clk): `write_Enable`=1; CS, A0 and data unchanged.
  - W_RECOV (1 clk): `chip_select`=1, `data_oe`=0.
  - Then the next word, or READY. `init_done` rises when READY is entered.
- READY:
  - Pending EOI has priority over INT. It runs one write cycle with A0=0, data = captured `eoi_cmd`, then returns to READY.
  - Otherwise, synchronized `INT`=1 → ACK1.
- `INT` passes through a 2-flop synchronizer. It is ignored outside READY.
- Acknowledge sequence:
  - ACK1: `INTA`=0 for `PULSE_CYCLES`.
  - ACK_GAP: `INTA`=1 for 2 clks.
  - ACK2: `INTA`=0 for `PULSE_CYCLES`; `data_in` sampled on the final ACK2 edge.
  - ACK_END (1 clk): `INTA`=1, `vector` updated, `vector_valid`=1, `data_oe`=0 throughout; then READY.
- `INT` deasserting mid-sequence does not abort it. The sequence completes and captures whatever the PIC drives (spurious IR7 vector).
- `eoi_req` arriving while busy sets a 1-deep pending flag and `eoi_cmd` is latched; a second request before service overwrites the command. `eoi_req` in IDLE is ignored.
- `start`:
  - Accepted in IDLE or READY: clears `init_done` and the pending EOI, then begins writes.
  - Ignored in all other states.

## Timing
- Reset values: `chip_select`=1, `write_Enable`=1, `read_Enable`=1, `INTA`=1, `A0`=0, `data_out`=0, `data_oe`=0, `busy`=0, `init_done`=0, `vector`=0, `vector_valid`=0; state IDLE.
- Reset mid-operation deasserts all strobes immediately (asynchronously), with no partial-cycle completion.
- Write cycle length = `PULSE_CYCLES`+3 clks. W_SETUP begins the clock after `start` is sampled.
- Init latency, `start` to `init_done`: N×(`PULSE_CYCLES`+3)+1 clks, N = number of words (2–4).
- `INT` rise to `INTA` fall: 3 clks (2 sync + state transition).
- Ack sequence length = 2×`PULSE_CYCLES`+3 clks.
- `busy`=1 in every state except IDLE and READY.

## Test plan
- Defaults, `start` at t0 → four writes (A0,data) = (0,11),(1,08),(1,04),(1,01), each with `write_Enable` low for exactly 2 clks; `init_done` at t0+21.
- ICW1=8'h13 → three writes (0,13),(1,08),(1,01), no ICW3; `init_done` at t0+16.
- After init, raise `INT`, `data_in`=8'h0C during ACK2 → two 2-clk `INTA` pulses separated by 2 clks; `vector`=8'h0C with a 1-clk `vector_valid`.
- `eoi_req` with `eoi_cmd`=8'h20 during an ack sequence → after `vector_valid`, one write (0,20); a simultaneous `INT` is serviced only after that write.
- Assert `reset` mid-W_STROBE → `write_Enable`, `chip_select` and `INTA` read 1 within the same cycle; `init_done`=0; a new `start` reprograms from ICW1.
- `start` pulsed during an ack, and `eoi_req` in IDLE → both ignored, with no bus activity.
